// File: rtl/pipe_reg_bus_pkg.sv
// pipe_reg_bus_pkg
//   Shared definitions for the pipeline-register bus reader: reader state
//   encoding, default shared-bus width and the inactive level of the
//   active-low source selects.
package pipe_reg_bus_pkg;

   localparam int unsigned DEFAULT_BUS_WIDTH = 32;
   localparam logic        CS_INACTIVE       = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TURN   = 3'd1,
      SELECT = 3'd2,
      SAMPLE = 3'd3,
      HOLD   = 3'd4
   } reader_state_t;

endpackage

// File: rtl/pipe_reg_bus_reader_lowest_set_index.sv
// lowest_set_index
//   Combinational priority encoder: index of the lowest set bit of mask.
//   Ports:
//     mask   in   NrOfSources  bits to scan
//     index  out  SelWidth     position of lowest set bit (0 when mask==0)
//     any    out  1            mask has at least one bit set
module lowest_set_index #(
   parameter int unsigned NrOfSources = 4,
   parameter int unsigned SelWidth    = 2
) (
   input  logic [NrOfSources-1:0] mask,
   output logic [SelWidth-1:0]    index,
   output logic                   any
);

   logic found;

   always_comb begin
      index = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NrOfSources; i++) begin
         if (mask[i] && !found) begin
            index = SelWidth'(i);
            found = 1'b1;
         end
      end
      any = found;
   end

endmodule

// File: rtl/pipe_reg_bus_reader.sv
// pipe_reg_bus_reader
//   Reader end of the shared tri-state pipeline-register bus. Walks the
//   captured source mask in ascending order, pulling one active-low cs line
//   at a time with all-released turnaround Ticks in between, samples Bus and
//   offers each word on a valid/ready stream.
//   Ports:
//     Clock, Reset       rising-edge clock, async active-high reset
//     Tick               clock enable; state advances only when high
//     Start, SrcMask     begin a scan of the given sources (IDLE only)
//     Bus                resolved shared bus value
//     cs                 per-source select, active-low
//     OutValid/OutReady  output handshake (accepted on Tick edges)
//     OutData, OutIndex  sampled word and its source index
//     Busy               scan in progress
//     Done               one-Tick pulse at end of scan
//     OutParity          XOR-reduce of OutData (PIPE_REG_READER_PARITY_EN only)
//   Build option: define PIPE_REG_READER_PARITY_EN to add OutParity.
module pipe_reg_bus_reader
   import pipe_reg_bus_pkg::*;
#(
   parameter int unsigned NrOfBits    = DEFAULT_BUS_WIDTH,
   parameter int unsigned NrOfSources = 4,
   parameter int unsigned SelWidth    = 2,
   parameter int unsigned TurnCycles  = 1
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   Tick,
   input  logic                   Start,
   input  logic [NrOfSources-1:0] SrcMask,
   input  logic [NrOfBits-1:0]    Bus,
   output logic [NrOfSources-1:0] cs,
   output logic                   OutValid,
   input  logic                   OutReady,
   output logic [NrOfBits-1:0]    OutData,
   output logic [SelWidth-1:0]    OutIndex,
   output logic                   Busy,
   output logic                   Done
`ifdef PIPE_REG_READER_PARITY_EN
  ,output logic                   OutParity
`endif
);

   localparam logic [1:0] TURN_LAST = 2'(TurnCycles - 1);

   reader_state_t          state, state_nxt;
   logic [NrOfSources-1:0] mask_q;
   logic [1:0]             turn_cnt;
   logic [SelWidth-1:0]    idx;
   logic                   any_left;

   lowest_set_index #(
      .NrOfSources (NrOfSources),
      .SelWidth    (SelWidth)
   ) u_scan (
      .mask  (mask_q),
      .index (idx),
      .any   (any_left)
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         state <= IDLE;
      else if (Tick)
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (Start && (SrcMask != '0)) state_nxt = TURN;
         TURN:    if (turn_cnt == TURN_LAST)    state_nxt = SELECT;
         SELECT:  state_nxt = SAMPLE;
         SAMPLE:  state_nxt = HOLD;
         HOLD:    if (OutReady) state_nxt = any_left ? TURN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // cs decodes straight from the state register so an async reset
   // releases the bus in the same cycle.
   always_comb begin
      cs = {NrOfSources{CS_INACTIVE}};
      if ((state == SELECT) || (state == SAMPLE))
         cs[idx] = ~CS_INACTIVE;
   end

   assign Busy = (state != IDLE);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         mask_q    <= '0;
         turn_cnt  <= '0;
         OutValid  <= 1'b0;
         OutData   <= '0;
         OutIndex  <= '0;
         Done      <= 1'b0;
`ifdef PIPE_REG_READER_PARITY_EN
         OutParity <= 1'b0;
`endif
      end else if (Tick) begin
         Done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (Start) begin
                  if (SrcMask != '0) begin
                     mask_q   <= SrcMask;
                     turn_cnt <= '0;
                  end else begin
                     Done <= 1'b1;
                  end
               end
            end
            TURN: begin
               turn_cnt <= (turn_cnt == TURN_LAST) ? 2'd0 : turn_cnt + 2'd1;
            end
            SAMPLE: begin
               OutData     <= Bus;
               OutIndex    <= idx;
               OutValid    <= 1'b1;
               mask_q[idx] <= 1'b0;
`ifdef PIPE_REG_READER_PARITY_EN
               OutParity   <= ^Bus;
`endif
            end
            HOLD: begin
               if (OutReady) begin
                  OutValid <= 1'b0;
                  if (!any_left)
                     Done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_reg_bus_reader.sv
// tb_pipe_reg_bus_reader
//   Randomized scoreboard bench for pipe_reg_bus_reader (4 sources, 32-bit
//   bus, one turnaround Tick). Expected words come from walking the scan
//   mask in ascending order; a negedge monitor checks handshakes, cs
//   exclusivity, Done pulses and that Tick=0 edges change nothing.
module tb_pipe_reg_bus_reader;

   localparam int NB = 32;
   localparam int NS = 4;
   localparam int TC = 1;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Tick;
   logic          Start;
   logic [NS-1:0] SrcMask;
   logic [NB-1:0] Bus;
   logic [NS-1:0] cs;
   logic          OutValid;
   logic          OutReady;
   logic [NB-1:0] OutData;
   logic [1:0]    OutIndex;
   logic          Busy;
   logic          Done;
`ifdef PIPE_REG_READER_PARITY_EN
   logic          OutParity;
`endif

   pipe_reg_bus_reader #(
      .NrOfBits    (NB),
      .NrOfSources (NS),
      .SelWidth    (2),
      .TurnCycles  (TC)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Tick     (Tick),
      .Start    (Start),
      .SrcMask  (SrcMask),
      .Bus      (Bus),
      .cs       (cs),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .OutData  (OutData),
      .OutIndex (OutIndex),
      .Busy     (Busy),
      .Done     (Done)
`ifdef PIPE_REG_READER_PARITY_EN
     ,.OutParity(OutParity)
`endif
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Source registers; a single low cs line puts that source on the bus.
   logic [NB-1:0] vals [NS];
   always_comb begin
      Bus = 32'h5A5A_5A5A;
      for (int i = 0; i < NS; i++)
         if (cs[i] == 1'b0) Bus = vals[i];
   end

   // Tick / OutReady drivers (mode 2 on OutReady = driven by test sequence).
   int tick_mode  = 0;
   int ready_mode = 0;
   int phase      = 0;
   always @(posedge Clock) begin
      #1;
      case (tick_mode)
         0: Tick = 1'b1;
         1: begin Tick = (phase == 0); phase = (phase + 1) % 3; end
         default: Tick = 1'($urandom_range(0, 1));
      endcase
      case (ready_mode)
         0: OutReady = 1'b1;
         1: OutReady = 1'($urandom_range(0, 1));
         default: ;
      endcase
   end

   // Scoreboard
   logic [33:0] exp_q [$];
   int          done_exp  = 0;
   int          done_seen = 0;
   int          tick_cnt  = 0;
   int          rise_q [$];

   logic        hold_chk = 1'b0;
   logic        snap_ok  = 1'b0;
   logic [63:0] snap;
   logic        prev_valid = 1'b0;
   int          prev_zeros = 0;
   int          prev_sel   = 0;

   always @(posedge Clock) begin
      hold_chk = !Tick && !Reset;
      if (Tick && !Reset) tick_cnt++;
   end

   always @(negedge Clock) begin
      int zeros;
      int sel;
      logic [63:0] now;
      logic [33:0] e;
      zeros = 0;
      sel   = 0;
      for (int i = 0; i < NS; i++)
         if (cs[i] == 1'b0) begin zeros++; sel = i; end
      if (zeros != 0) begin
         chk("cs_single_select", 64'(zeros <= 1), 64'd1);
         if (prev_zeros == 1 && zeros == 1)
            chk("cs_adjacent_select", 64'(sel), 64'(prev_sel));
      end
      prev_zeros = zeros;
      prev_sel   = sel;

      now = {23'd0, cs, OutValid, OutData, OutIndex, Busy, Done};
      if (hold_chk && snap_ok && !Reset)
         chk("tick0_hold", now, snap);
      snap    = now;
      snap_ok = !Reset;

      if (OutValid && !prev_valid) rise_q.push_back(tick_cnt);
      prev_valid = OutValid;

      if (OutValid && OutReady && Tick && !Reset) begin
         if (exp_q.size() == 0) begin
            chk("word_unexpected", {30'd0, OutIndex, OutData}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("word_index", 64'(OutIndex), 64'(e[33:32]));
            chk("word_data", 64'(OutData), 64'(e[31:0]));
`ifdef PIPE_REG_READER_PARITY_EN
            chk("word_parity", 64'(OutParity), 64'(^e[31:0]));
`endif
         end
      end
      if (Done && Tick && !Reset) done_seen++;
   end

   // Reference: one word per set mask bit, lowest index first, then one Done.
   task automatic start_scan(input logic [NS-1:0] m);
      logic got;
      for (int i = 0; i < NS; i++)
         if (m[i]) exp_q.push_back({2'(i), vals[i]});
      done_exp++;
      SrcMask = m;
      Start   = 1'b1;
      got     = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(posedge Clock);
         if (Tick) got = 1'b1;
      end
      if (!got) chk("start_tick_timeout", 64'd0, 64'd1);
      #1 Start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      logic idle;
      idle = 1'b0;
      for (int i = 0; i < budget && !idle; i++) begin
         @(negedge Clock);
         if (exp_q.size() == 0 && !Busy && !Done) idle = 1'b1;
      end
      if (!idle) begin
         chk("scan_timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
      end
      chk("done_count", 64'(done_seen), 64'(done_exp));
      done_seen = done_exp;
   endtask

   initial begin
      logic got;
      Reset = 1'b1; Tick = 1'b0; Start = 1'b0; SrcMask = '0; OutReady = 1'b0;
      for (int i = 0; i < NS; i++) vals[i] = '0;
      #1;
      chk("rst_cs", 64'(cs), 64'hF);
      chk("rst_valid", 64'(OutValid), 64'd0);
      chk("rst_data", 64'(OutData), 64'd0);
      chk("rst_index", 64'(OutIndex), 64'd0);
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_done", 64'(Done), 64'd0);
      repeat (2) @(posedge Clock);
      #2 Reset = 1'b0;
      repeat (2) @(negedge Clock);

      // Full scan, Tick=1, OutReady=1: words 4 Ticks apart.
      vals[0] = 32'hA000_0000; vals[1] = 32'h0000_00B1;
      vals[2] = 32'h0000_00C2; vals[3] = 32'h0000_00D3;
      rise_q.delete();
      start_scan(4'b1111);
      wait_idle(500);
      chk("full_word_count", 64'(rise_q.size()), 64'd4);
      for (int i = 1; i < rise_q.size(); i++)
         chk("full_word_spacing", 64'(rise_q[i] - rise_q[i-1]), 64'(TC + 3));

      // Same scan with Tick pattern 1,0,0: same words, stretched.
      tick_mode = 1;
      start_scan(4'b1111);
      wait_idle(1000);
      tick_mode = 0;

      // Sparse mask with a 5-Tick stall on the first word; Start and a
      // new SrcMask during the stall must be ignored.
      ready_mode = 2; OutReady = 1'b0;
      vals[1] = $urandom; vals[3] = $urandom;
      start_scan(4'b1010);
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge Clock);
         if (OutValid) got = 1'b1;
      end
      chk("stall_valid_seen", 64'(got), 64'd1);
      @(posedge Clock); #1 Start = 1'b1; SrcMask = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         chk("stall_cs", 64'(cs), 64'hF);
         chk("stall_index", 64'(OutIndex), 64'd1);
         chk("stall_valid", 64'(OutValid), 64'd1);
         chk("stall_busy", 64'(Busy), 64'd1);
      end
      @(posedge Clock); #1 Start = 1'b0; OutReady = 1'b1; ready_mode = 0;
      wait_idle(500);

      // Empty mask: Done pulse only.
      start_scan(4'b0000);
      @(negedge Clock);
      chk("empty_busy", 64'(Busy), 64'd0);
      wait_idle(50);

      // Parity-oriented words (7 -> odd, 3 -> even).
      vals[0] = 32'h0000_0007; vals[1] = 32'h0000_0003;
      start_scan(4'b0011);
      wait_idle(500);

      // Randomized scans.
      for (int s = 0; s < 10; s++) begin
         tick_mode  = $urandom_range(0, 2);
         ready_mode = $urandom_range(0, 1);
         for (int i = 0; i < NS; i++) vals[i] = $urandom;
         start_scan(4'($urandom_range(0, 15)));
         wait_idle(3000);
      end
      tick_mode = 0; ready_mode = 0;
      @(negedge Clock);

      // Reset while source 2 is selected.
      vals[2] = 32'h1234_5678;
      start_scan(4'b0100);
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge Clock);
         if (cs == 4'b1011) got = 1'b1;
      end
      chk("rstmid_select_seen", 64'(got), 64'd1);
      #1 Reset = 1'b1;
      #1;
      chk("rstmid_cs", 64'(cs), 64'hF);
      chk("rstmid_valid", 64'(OutValid), 64'd0);
      chk("rstmid_busy", 64'(Busy), 64'd0);
      exp_q.delete();
      done_exp--;
      @(posedge Clock); #3 Reset = 1'b0;
      repeat (3) @(negedge Clock);
      chk("rstrel_busy", 64'(Busy), 64'd0);
      chk("rstrel_cs", 64'(cs), 64'hF);
      chk("rstrel_valid", 64'(OutValid), 64'd0);
      wait_idle(50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
